// File: rtl/obj_pkg.sv
// Shared types for the OBJ line scanner: FSM states, OAM shape/size codes
// and the constant dimension table that maps them to base pixel sizes.
package obj_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_EVAL = 3'd2,
        ST_EMIT = 3'd3,
        ST_DONE = 3'd4
    } scan_state_t;

    typedef enum logic [1:0] {
        SHAPE_SQUARE  = 2'd0,
        SHAPE_WIDE    = 2'd1,
        SHAPE_TALL    = 2'd2,
        SHAPE_INVALID = 2'd3
    } obj_shape_t;

    typedef logic [1:0] obj_size_t;

    typedef struct packed {
        logic [7:0] w;
        logic [7:0] h;
    } obj_dims_t;

    // Base width/height for a shape/size pair; the invalid shape yields 0x0.
    function automatic obj_dims_t obj_dims(input obj_shape_t shape, input obj_size_t size);
        obj_dims_t d;
        d.w = 8'd0;
        d.h = 8'd0;
        case ({shape, size})
            4'b00_00: begin d.w = 8'd8;  d.h = 8'd8;  end
            4'b00_01: begin d.w = 8'd16; d.h = 8'd16; end
            4'b00_10: begin d.w = 8'd32; d.h = 8'd32; end
            4'b00_11: begin d.w = 8'd64; d.h = 8'd64; end
            4'b01_00: begin d.w = 8'd16; d.h = 8'd8;  end
            4'b01_01: begin d.w = 8'd32; d.h = 8'd8;  end
            4'b01_10: begin d.w = 8'd32; d.h = 8'd16; end
            4'b01_11: begin d.w = 8'd64; d.h = 8'd32; end
            4'b10_00: begin d.w = 8'd8;  d.h = 8'd16; end
            4'b10_01: begin d.w = 8'd8;  d.h = 8'd32; end
            4'b10_10: begin d.w = 8'd16; d.h = 8'd32; end
            4'b10_11: begin d.w = 8'd32; d.h = 8'd64; end
            default:  begin d.w = 8'd0;  d.h = 8'd0;  end
        endcase
        return d;
    endfunction

endpackage

// File: rtl/obj_attr_decode.sv
// Combinational decode of one OAM entry: bounding box size and wrap-aware
// test of whether the current scanline falls inside the object.
module obj_attr_decode
    import obj_pkg::*;
(
    input  logic [15:0] i_attr0,
    input  logic [15:0] i_attr1,
    input  logic [7:0]  i_row,
    output logic        o_visible,
    output logic [6:0]  o_dy,
    output logic [7:0]  o_hsize,
    output logic [7:0]  o_vsize
);

    logic       w_disable;
    logic       w_dbl;
    obj_shape_t w_shape;
    obj_dims_t  w_dims;
    logic [7:0] w_diff;
    logic       w_unused_bits;

    assign w_disable = i_attr0[9] & ~i_attr0[8];
    assign w_dbl     = i_attr0[9] &  i_attr0[8];
    assign w_shape   = obj_shape_t'(i_attr0[15:14]);
    assign w_dims    = obj_dims(w_shape, i_attr1[15:14]);

    // Largest base dimension is 64, so the doubled size still fits in 8 bits.
    assign o_hsize = w_dbl ? {w_dims.w[6:0], 1'b0} : w_dims.w;
    assign o_vsize = w_dbl ? {w_dims.h[6:0], 1'b0} : w_dims.h;

    // Modulo-256 difference lets objects with Y near the bottom wrap onto row 0.
    assign w_diff    = i_row - i_attr0[7:0];
    assign o_dy      = w_diff[6:0];
    assign o_visible = ~w_disable & (w_shape != SHAPE_INVALID) & (w_diff < o_vsize);

    assign w_unused_bits = ^{i_attr0[13:10], i_attr1[13:0]};

endmodule

// File: rtl/obj_line_scanner.sv
// Per-scanline OBJ evaluator: walks OAM in ascending order, decodes each entry
// and forwards visible objects to the render queue, up to a per-line limit.
module obj_line_scanner
    import obj_pkg::*;
#(
    parameter int NUM_OBJ      = 128,
    parameter int MAX_PER_LINE = 32,
    parameter int IDX_W        = 7
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       row,
    output logic             oam_rd,
    output logic [IDX_W-1:0] oam_addr,
    input  logic             oam_ack,
    input  logic [15:0]      oam_attr0,
    input  logic [15:0]      oam_attr1,
    output logic             vis_valid,
    input  logic             vis_ready,
    output logic [IDX_W-1:0] vis_index,
    output logic [6:0]       vis_dy,
    output logic [7:0]       vis_hsize,
    output logic [7:0]       vis_vsize,
    output logic             busy,
    output logic             done,
    output logic             overflow
);

    localparam int               CNT_W    = IDX_W + 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_OBJ - 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PER_LINE);

    scan_state_t      r_state;
    logic [7:0]       r_row;
    logic [IDX_W-1:0] r_entry;
    logic [CNT_W-1:0] r_emit_cnt;
    logic [15:0]      r_attr0;
    logic [15:0]      r_attr1;
    logic             r_oam_rd;
    logic             r_vis_valid;
    logic [IDX_W-1:0] r_vis_index;
    logic [6:0]       r_vis_dy;
    logic [7:0]       r_vis_hsize;
    logic [7:0]       r_vis_vsize;
    logic             r_busy;
    logic             r_done;
    logic             r_overflow;

    logic             w_visible;
    logic [6:0]       w_dy;
    logic [7:0]       w_hsize;
    logic [7:0]       w_vsize;
    logic             w_accept;
    logic             w_advance;
    logic             w_last;
    logic             w_limit;
    logic [CNT_W-1:0] w_cnt_after;

    obj_attr_decode u_decode (
        .i_attr0   (r_attr0),
        .i_attr1   (r_attr1),
        .i_row     (r_row),
        .o_visible (w_visible),
        .o_dy      (w_dy),
        .o_hsize   (w_hsize),
        .o_vsize   (w_vsize)
    );

    assign w_accept    = (r_state == ST_EMIT) & vis_ready;
    assign w_advance   = ((r_state == ST_EVAL) & ~w_visible) | w_accept;
    assign w_cnt_after = r_emit_cnt + CNT_W'(w_accept);
    assign w_last      = (r_entry == LAST_IDX);
    assign w_limit     = (w_cnt_after == MAX_CNT);

    // Scan sequencer: fetch entry, evaluate, emit, then step or finish the line.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_row       <= 8'd0;
            r_entry     <= '0;
            r_emit_cnt  <= '0;
            r_attr0     <= 16'd0;
            r_attr1     <= 16'd0;
            r_oam_rd    <= 1'b0;
            r_vis_valid <= 1'b0;
            r_vis_index <= '0;
            r_vis_dy    <= 7'd0;
            r_vis_hsize <= 8'd0;
            r_vis_vsize <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        r_row      <= row;
                        r_entry    <= '0;
                        r_emit_cnt <= '0;
                        r_overflow <= 1'b0;
                        r_busy     <= 1'b1;
                        r_oam_rd   <= 1'b1;
                        r_state    <= ST_REQ;
                    end else begin
                        r_state    <= ST_IDLE;
                    end
                end
                ST_REQ: begin
                    if (oam_ack) begin
                        r_attr0  <= oam_attr0;
                        r_attr1  <= oam_attr1;
                        r_oam_rd <= 1'b0;
                        r_state  <= ST_EVAL;
                    end else begin
                        r_state  <= ST_REQ;
                    end
                end
                ST_EVAL: begin
                    if (w_visible) begin
                        r_vis_valid <= 1'b1;
                        r_vis_index <= r_entry;
                        r_vis_dy    <= w_dy;
                        r_vis_hsize <= w_hsize;
                        r_vis_vsize <= w_vsize;
                        r_state     <= ST_EMIT;
                    end else begin
                        r_vis_valid <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (vis_ready) begin
                        r_vis_valid <= 1'b0;
                        r_emit_cnt  <= w_cnt_after;
                    end else begin
                        r_vis_valid <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_oam_rd    <= 1'b0;
                    r_vis_valid <= 1'b0;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase

            // Overrides the state hold above whenever the current entry is retired.
            if (w_advance) begin
                if (w_last) begin
                    r_busy   <= 1'b0;
                    r_done   <= 1'b1;
                    r_state  <= ST_DONE;
                end else if (w_limit) begin
                    r_busy     <= 1'b0;
                    r_done     <= 1'b1;
                    r_overflow <= 1'b1;
                    r_state    <= ST_DONE;
                end else begin
                    r_entry  <= r_entry + IDX_W'(1);
                    r_oam_rd <= 1'b1;
                    r_state  <= ST_REQ;
                end
            end
        end
    end

    assign oam_rd    = r_oam_rd;
    assign oam_addr  = r_entry;
    assign vis_valid = r_vis_valid;
    assign vis_index = r_vis_index;
    assign vis_dy    = r_vis_dy;
    assign vis_hsize = r_vis_hsize;
    assign vis_vsize = r_vis_vsize;
    assign busy      = r_busy;
    assign done      = r_done;
    assign overflow  = r_overflow;

endmodule

// File: tb/tb_obj_line_scanner.sv
// Directed bench for obj_line_scanner: OAM responder with one-cycle ack,
// record monitor, and hand-computed expectations checked by assertions.
module tb_obj_line_scanner;

    localparam int NUM_OBJ      = 128;
    localparam int MAX_PER_LINE = 32;
    localparam int IDX_W        = 7;

    logic             clock = 1'b0;
    logic             reset;
    logic             start;
    logic [7:0]       row;
    logic             oam_rd;
    logic [IDX_W-1:0] oam_addr;
    logic             oam_ack = 1'b0;
    logic [15:0]      oam_attr0 = 16'd0;
    logic [15:0]      oam_attr1 = 16'd0;
    logic             vis_valid;
    logic             vis_ready;
    logic [IDX_W-1:0] vis_index;
    logic [6:0]       vis_dy;
    logic [7:0]       vis_hsize;
    logic [7:0]       vis_vsize;
    logic             busy;
    logic             done;
    logic             overflow;

    logic [15:0] mem0 [NUM_OBJ];
    logic [15:0] mem1 [NUM_OBJ];
    logic [31:0] recs [$];
    int done_cnt  = 0;
    int reads     = 0;
    int last_addr = -1;
    int base_recs, base_done, base_reads;
    int vectors     = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    obj_line_scanner #(
        .NUM_OBJ      (NUM_OBJ),
        .MAX_PER_LINE (MAX_PER_LINE),
        .IDX_W        (IDX_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .row       (row),
        .oam_rd    (oam_rd),
        .oam_addr  (oam_addr),
        .oam_ack   (oam_ack),
        .oam_attr0 (oam_attr0),
        .oam_attr1 (oam_attr1),
        .vis_valid (vis_valid),
        .vis_ready (vis_ready),
        .vis_index (vis_index),
        .vis_dy    (vis_dy),
        .vis_hsize (vis_hsize),
        .vis_vsize (vis_vsize),
        .busy      (busy),
        .done      (done),
        .overflow  (overflow)
    );

    // OAM RAM model: answers a held request with a single-cycle ack
    always @(negedge clock) begin
        if (oam_rd && !oam_ack) begin
            oam_ack   = 1'b1;
            oam_attr0 = mem0[oam_addr];
            oam_attr1 = mem1[oam_addr];
            reads++;
            last_addr = int'(oam_addr);
        end else begin
            oam_ack = 1'b0;
        end
    end

    // Record monitor: logs accepted records and done pulses
    always @(negedge clock) begin
        if (vis_valid && vis_ready) recs.push_back({2'b00, vis_index, vis_dy, vis_hsize, vis_vsize});
        if (done) done_cnt++;
    end

    function automatic logic [31:0] mk_rec(input int idx, input int dy, input int h, input int v);
        return {2'b00, 7'(idx), 7'(dy), 8'(h), 8'(v)};
    endfunction

    function automatic logic [31:0] get_rec(input int i);
        if (recs.size() > base_recs + i) return recs[base_recs + i];
        else return 32'hFFFF_FFFF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input logic [15:0] a0, input logic [15:0] a1);
        for (int i = 0; i < NUM_OBJ; i++) begin
            mem0[i] = a0;
            mem1[i] = a1;
        end
    endtask

    task automatic start_pulse(input logic [7:0] r);
        base_recs  = recs.size();
        base_done  = done_cnt;
        base_reads = reads;
        @(posedge clock); #1;
        row   = r;
        start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done();
        int cyc = 0;
        while (done_cnt == base_done && cyc < 3000) begin
            @(negedge clock);
            cyc++;
        end
        check("done_timeout", 32'(cyc < 3000), 32'd1);
        @(negedge clock);
    endtask

    task automatic wait_valid();
        int cyc = 0;
        while (!vis_valid && cyc < 200) begin
            @(negedge clock);
            cyc++;
        end
        check("valid_timeout", 32'(cyc < 200), 32'd1);
    endtask

    task automatic run_scan(input logic [7:0] r);
        start_pulse(r);
        wait_done();
    endtask

    initial begin
        reset     = 1'b0;
        start     = 1'b0;
        row       = 8'd0;
        vis_ready = 1'b1;
        fill(16'h0200, 16'h0000);
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_ctrl", 32'({busy, done, overflow, vis_valid, oam_rd}), 32'd0);
        check("rst_addr", 32'(oam_addr), 32'd0);
        check("rst_vis", {2'b00, vis_index, vis_dy, vis_hsize, vis_vsize}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;

        // Single square 16x16 at Y=16, row 20
        mem0[0] = 16'h0010; mem1[0] = 16'h4000;
        run_scan(8'd20);
        check("t1_count", 32'(recs.size() - base_recs), 32'd1);
        check("t1_rec", get_rec(0), mk_rec(0, 4, 16, 16));
        check("t1_done", 32'(done_cnt - base_done), 32'd1);
        check("t1_ovf_busy", 32'({overflow, busy}), 32'd0);
        check("t1_reads", 32'(reads - base_reads), 32'd128);
        mem0[0] = 16'h0200; mem1[0] = 16'h0000;

        // Y=250 wraps onto row 3; at row 10 dy=16 falls outside
        mem0[5] = 16'h00FA; mem1[5] = 16'h4000;
        run_scan(8'd3);
        check("t2_count", 32'(recs.size() - base_recs), 32'd1);
        check("t2_rec", get_rec(0), mk_rec(5, 9, 16, 16));
        run_scan(8'd10);
        check("t2_nowrap", 32'(recs.size() - base_recs), 32'd0);
        mem0[5] = 16'h0200; mem1[5] = 16'h0000;

        // Affine double-size 8x8 -> 16x16; then disabled; then invalid shape
        mem0[0] = 16'h0330; mem1[0] = 16'h0000;
        run_scan(8'd60);
        check("t3_count", 32'(recs.size() - base_recs), 32'd1);
        check("t3_rec", get_rec(0), mk_rec(0, 12, 16, 16));
        mem0[0] = 16'h0230;
        run_scan(8'd60);
        check("t3_disabled", 32'(recs.size() - base_recs), 32'd0);
        mem0[0] = 16'hC000;
        run_scan(8'd0);
        check("t3_shape3", 32'(recs.size() - base_recs), 32'd0);

        // Every entry visible: limit reached at 32
        fill(16'h0000, 16'h0000);
        run_scan(8'd0);
        check("t4_count", 32'(recs.size() - base_recs), 32'd32);
        for (int i = 0; i < MAX_PER_LINE; i++) check("t4_order", get_rec(i), mk_rec(i, 0, 8, 8));
        check("t4_reads", 32'(reads - base_reads), 32'd32);
        check("t4_last_addr", 32'(last_addr), 32'd31);
        check("t4_overflow", 32'({overflow, busy}), 32'b10);
        check("t4_done", 32'(done_cnt - base_done), 32'd1);

        // Back-pressure on entry 2, a stray start, then entry 7
        fill(16'h0200, 16'h0000);
        mem0[2] = 16'h0000; mem0[7] = 16'h0000;
        vis_ready = 1'b0;
        start_pulse(8'd5);
        wait_valid();
        @(posedge clock); #1;
        row = 8'd99; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("t5_hold", {busy, vis_valid, oam_rd, vis_index, vis_dy, vis_hsize, vis_vsize},
                  {1'b1, 1'b1, 1'b0, 7'd2, 7'd5, 8'd8, 8'd8});
        end
        @(posedge clock); #1;
        vis_ready = 1'b1;
        wait_done();
        check("t5_count", 32'(recs.size() - base_recs), 32'd2);
        check("t5_rec0", get_rec(0), mk_rec(2, 5, 8, 8));
        check("t5_rec1", get_rec(1), mk_rec(7, 5, 8, 8));
        check("t5_done", 32'(done_cnt - base_done), 32'd1);
        check("t5_overflow", 32'(overflow), 32'd0);

        // Reset while a record is stalled in EMIT
        fill(16'h0200, 16'h0000);
        mem0[3] = 16'h0000;
        vis_ready = 1'b0;
        start_pulse(8'd5);
        wait_valid();
        check("t6_pre_idx", 32'(vis_index), 32'd3);
        @(posedge clock); #1;
        reset = 1'b0;
        @(negedge clock);
        check("t6_in_reset", 32'({vis_valid, oam_rd, busy, done, overflow}), 32'd0);
        @(posedge clock); #1;
        reset = 1'b1;
        base_done = done_cnt;
        repeat (5) @(negedge clock);
        check("t6_no_stale", 32'({done_cnt != base_done, vis_valid, busy}), 32'd0);
        vis_ready = 1'b1;
        mem0[0] = 16'h0000; mem1[0] = 16'h4000;
        run_scan(8'd0);
        check("t6_count", 32'(recs.size() - base_recs), 32'd2);
        check("t6_rec0", get_rec(0), mk_rec(0, 0, 16, 16));
        check("t6_rec1", get_rec(1), mk_rec(3, 0, 8, 8));
        check("t6_done", 32'(done_cnt - base_done), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/obj_line_scanner.md
Name: obj_line_scanner

Overview:
Per-scanline OBJ evaluator. On a start pulse for a given row, it walks OAM entries 0..NUM_OBJ-1 over a request/acknowledge read port. For each entry it decodes shape, size and the affine/double-size flags, tests whether the row is inside the object using wrap-aware Y arithmetic, and pushes each visible object into the downstream OBJ render queue over a valid/ready handshake. It sits between the OAM RAM and the OBJ pixel fetch/render pipeline, and generalises the single-object row visibility check to a full-line scan with a per-line limit.

Parameters:
NUM_OBJ, 128, number of OAM entries scanned per line (power of 2, 2..128)
MAX_PER_LINE, 32, maximum visible objects emitted per line (1..NUM_OBJ)
IDX_W, 7, index width; must equal clog2(NUM_OBJ)

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse: begin scan of row
row  in  8  scanline number, sampled on start
oam_rd  out  1  OAM read request; held until oam_ack
oam_addr  out  IDX_W  entry index being read
oam_ack  in  1  read data valid (one cycle, latency >=1)
oam_attr0  in  16  attr0 of addressed entry; valid with oam_ack
oam_attr1  in  16  attr1 of addressed entry; valid with oam_ack
vis_valid  out  1  visible-object record valid
vis_ready  in  1  downstream accepts record
vis_index  out  IDX_W  OAM index of visible object
vis_dy  out  7  row - objY (mod 256); line within object bounding box
vis_hsize  out  8  bounding width in pixels (doubled if affine double-size)
vis_vsize  out  8  bounding height in pixels (doubled if affine double-size)
busy  out  1  scan in progress
done  out  1  one-cycle pulse when the scan completes
overflow  out  1  sticky per line: MAX_PER_LINE reached with entries left to scan

Behaviour:
- Reset values: all outputs are 0, the FSM is in IDLE, and the counters are cleared.
- FSM states: IDLE, REQ, EVAL, EMIT, DONE.
- IDLE: on start, latch row, clear the entry and emit counters, clear overflow, and go to REQ. busy=1 from the next cycle.
- start while busy: ignored. The latched row is unchanged.
- REQ: drive oam_rd=1 and oam_addr=entry counter. When oam_ack=1, register attr0/attr1 and go to EVAL. oam_rd deasserts in the cycle after ack.
- EVAL (one cycle), decode:
  - disable = attr0[9] & ~attr0[8]
  - affine = attr0[8], dbl = attr0[9] & attr0[8]
  - shape = attr0[15:14], size = attr1[15:14]
  - base w/h from the size table:
    - shape 0: 8x8, 16x16, 32x32, 64x64
    - shape 1 (wide): 16x8, 32x8, 32x16, 64x32
    - shape 2 (tall): 8x16, 8x32, 16x32, 32x64
    - shape 3: invalid, treated as disabled
  - hsize = w << dbl, vsize = h << dbl
  - dy = (row - attr0[7:0]) mod 256, 8-bit wrap. This covers objects with Y>=160 that wrap from the top.
  - visible = ~disable & (dy < vsize). vsize is 128 at most, so compare with 8-bit dy.
  - Visible: go to EMIT. Otherwise advance the entry.
- EMIT: hold vis_valid=1 and all vis_* fields stable until vis_ready. On the accepting cycle, increment the emit counter and advance the entry.
- Advance entry:
  - If entry == NUM_OBJ-1: go to DONE.
  - Else if emit count == MAX_PER_LINE: go to DONE, and set overflow if any entry remains.
  - Else increment the entry and go to REQ.
- DONE: done=1 for one cycle, busy=0, then IDLE. overflow holds until the next start.
- Scan order is strictly ascending index, which gives the renderer its priority order.
- Latency per entry with 1-cycle ack: 3 cycles if invisible, 4+ if visible (back-pressure extends EMIT).
- Reset mid-scan: return to IDLE immediately. No done pulse, and the vis_* and oam_rd outputs drop.

Decomposition:
- Shared package obj_pkg:
  - scan_state_t enum
  - obj_shape_t / obj_size_t
  - constant size lookup function obj_dims(shape, size) returning {w,h}
- Sub-module obj_attr_decode (combinational): attr0, attr1, row in; visible, dy, hsize, vsize out. This is the wrap-aware successor of the row visibility check.
- The FSM and counters stay in obj_line_scanner.

Test Plan:
- row=20; entry0 attr0=0x0010 (Y=16, square), attr1=0x4000 (16x16); others disabled (attr0=0x0200) -> one record: index0, dy=4, hsize=16, vsize=16; done; overflow=0.
- row=3; entry5 Y=250, shape0 size1 -> visible via wrap, dy=9. Same object at row=10 -> dy=16, not visible.
- Affine double-size: attr0=0x0330 (Y=48, affine+dbl), attr1=size0; row=60 -> visible, dy=12, hsize=vsize=16. The same entry with attr0=0x0230 (disable) -> no record.
- All 128 entries visible with MAX_PER_LINE=32 -> exactly indices 0..31 emitted in order, then done; overflow=1.
- Back-pressure: vis_ready held low for 10 cycles during EMIT -> vis_* fields stable, no OAM request issued, and the scan resumes after ready. A start pulse mid-scan is ignored.
- Assert reset low mid-EMIT, release, then start row=0 -> no stale done or vis_valid. The new scan begins at entry 0 with correct results.
